// File: rtl/mini_alu_if.sv
// mini_alu_if -- operand/request/result bundle between a requester and mini_alu.
// The requester (master) drives the one-hot op and the operands; the ALU
// (slave) returns busy, the registered result and the error flag.
interface mini_alu_if;
  logic [3:0] alu_op_i;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic       alu_busy_o;
  logic [7:0] alu_o;
  logic       err_o;

  modport master (
    output alu_op_i, a_i, b_i,
    input  alu_busy_o, alu_o, err_o
  );

  modport slave (
    input  alu_op_i, a_i, b_i,
    output alu_busy_o, alu_o, err_o
  );
endinterface

// File: rtl/mini_alu.sv
// mini_alu -- 4-bit multi-cycle ALU: add/sub (1 cycle), shift-and-add multiply
// (4 cycles), restoring divide (4 cycles). The result and error flag are
// registered and change only when the FSM enters DONE. DONE waits for the
// request to drop to 0000 before re-arming, so a held request runs once.
// Optional feature: define MINI_ALU_DIV_EN to build the divider; without it
// a divide request completes like add/sub with alu_o = 8'h00 and err_o = 1.
module mini_alu (
  input  logic        clk,
  input  logic        rst,  // synchronous, active-low
  mini_alu_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDSUB,
    S_MUL,
`ifdef MINI_ALU_DIV_EN
    S_DIV,
`endif
    S_DONE
  } state_t;

  // What the single-cycle ADDSUB state should produce.
  typedef enum logic [1:0] {
    K_ADD,
    K_SUB,
    K_NODIV
  } kind_t;

  state_t      r_state;
  state_t      w_next_state;
  kind_t       r_kind;
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic [1:0]  r_cnt;
  logic [7:0]  r_acc;      // multiply partial product
  logic [7:0]  r_mcand;    // multiplicand, shifted left each step
  logic [3:0]  r_mplier;   // multiplier, shifted right each step
  logic [7:0]  r_alu;
  logic        r_err;

  logic        w_onehot;
  logic        w_accept;
  logic        w_busy;
  logic        w_load;
  logic [7:0]  w_result;
  logic        w_err;
  logic [7:0]  w_mul_next;

  assign w_onehot   = (bus.alu_op_i != 4'd0) &&
                      ((bus.alu_op_i & (bus.alu_op_i - 4'd1)) == 4'd0);
  assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : 8'd0);

`ifdef MINI_ALU_DIV_EN
  logic [3:0]  r_rem;      // partial remainder
  logic [3:0]  r_quo;      // dividend bits shifting out, quotient bits in
  logic [4:0]  w_rem_sh;
  logic [4:0]  w_diff;
  logic        w_fits;
  logic [3:0]  w_rem_next;
  logic [3:0]  w_quo_next;

  assign w_rem_sh   = {r_rem, r_quo[3]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_fits     = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_next = w_fits ? w_diff[3:0] : w_rem_sh[3:0];
  assign w_quo_next = {r_quo[2:0], w_fits};
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here -- it is just the highest-priority branch
    // inside the clocked block, not part of the sensitivity list.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode, busy, and the value to capture on entry to DONE.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_load       = 1'b0;
    w_result     = r_alu;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_accept = 1'b1;
          w_busy   = 1'b1;
          if (bus.alu_op_i[1])      w_next_state = S_MUL;
`ifdef MINI_ALU_DIV_EN
          else if (bus.alu_op_i[0]) w_next_state = S_DIV;
`endif
          else                      w_next_state = S_ADDSUB;
        end
      end
      S_ADDSUB: begin
        w_busy       = 1'b1;
        w_load       = 1'b1;
        w_next_state = S_DONE;
        case (r_kind)
          K_ADD:   w_result = {4'd0, r_a} + {4'd0, r_b};
          K_SUB:   w_result = {4'd0, r_a} - {4'd0, r_b};
          default: begin
            w_result = 8'h00;
            w_err    = 1'b1;
          end
        endcase
      end
      S_MUL: begin
        w_busy = 1'b1;
        if (r_cnt == 2'd3) begin
          w_load       = 1'b1;
          w_result     = w_mul_next;
          w_next_state = S_DONE;
        end
      end
`ifdef MINI_ALU_DIV_EN
      S_DIV: begin
        w_busy = 1'b1;
        if (r_b == 4'd0) begin
          w_load       = 1'b1;
          w_result     = 8'hFF;
          w_err        = 1'b1;
          w_next_state = S_DONE;
        end else if (r_cnt == 2'd3) begin
          w_load       = 1'b1;
          w_result     = {w_quo_next, w_rem_next};
          w_next_state = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (bus.alu_op_i == 4'd0) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (!rst) w_busy = 1'b0;
  end

  // Operand capture, iteration registers and the registered result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_kind   <= K_ADD;
      r_a      <= 4'd0;
      r_b      <= 4'd0;
      r_cnt    <= 2'd0;
      r_acc    <= 8'd0;
      r_mcand  <= 8'd0;
      r_mplier <= 4'd0;
      r_alu    <= 8'd0;
      r_err    <= 1'b0;
`ifdef MINI_ALU_DIV_EN
      r_rem    <= 4'd0;
      r_quo    <= 4'd0;
`endif
    end else begin
      if (w_accept) begin
        r_kind   <= bus.alu_op_i[3] ? K_ADD :
                    bus.alu_op_i[2] ? K_SUB : K_NODIV;
        r_a      <= bus.a_i;
        r_b      <= bus.b_i;
        r_cnt    <= 2'd0;
        r_acc    <= 8'd0;
        r_mcand  <= {4'd0, bus.a_i};
        r_mplier <= bus.b_i;
`ifdef MINI_ALU_DIV_EN
        r_rem    <= 4'd0;
        r_quo    <= bus.a_i;
`endif
      end else if (r_state == S_MUL) begin
        r_acc    <= w_mul_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 2'd1;
      end
`ifdef MINI_ALU_DIV_EN
      else if (r_state == S_DIV) begin
        r_rem    <= w_rem_next;
        r_quo    <= w_quo_next;
        r_cnt    <= r_cnt + 2'd1;
      end
`endif
      if (w_load) begin
        r_alu <= w_result;
        r_err <= w_err;
      end
    end
  end

  assign bus.alu_busy_o = w_busy;
  assign bus.alu_o      = r_alu;
  assign bus.err_o      = r_err;

endmodule

// File: tb/tb_mini_alu.sv
// tb_mini_alu -- randomized self-checking bench for mini_alu. The expected
// result and latency of each request come from plain arithmetic on the
// operands. Honours MINI_ALU_DIV_EN the same way as the design.
module tb_mini_alu;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [7:0] prev_alu;
  logic       prev_err;

  mini_alu_if u_if ();

  mini_alu u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected result, error flag and cycles from acceptance to DONE.
  task automatic model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       output logic [7:0] res, output logic err, output int lat);
    int ia, ib;
    ia = a;
    ib = b;
    err = 1'b0;
    lat = 2;
    res = 8'h00;
    case (op)
      4'b1000: res = 8'((ia + ib) & 255);
      4'b0100: res = 8'((ia - ib) & 255);
      4'b0010: begin res = 8'(ia * ib); lat = 5; end
      default: begin
`ifdef MINI_ALU_DIV_EN
        if (ib == 0) begin
          res = 8'hFF;
          err = 1'b1;
        end else begin
          res = 8'(((ia / ib) << 4) | (ia % ib));
          lat = 5;
        end
`else
        res = 8'h00;
        err = 1'b1;
`endif
      end
    endcase
  endtask

  // Issue one legal request, follow it to DONE, hold it, then release.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input int hold, input string tag);
    logic [7:0] exp_res;
    logic       exp_err;
    int         lat;
    model(a, b, op, exp_res, exp_err, lat);
    u_if.a_i      = a;
    u_if.b_i      = b;
    u_if.alu_op_i = op;
    #1;
    check({tag, ".busy_accept"}, u_if.alu_busy_o, 1);
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k < lat) begin
        check({tag, ".busy_run"}, u_if.alu_busy_o, 1);
        check({tag, ".alu_stable"}, u_if.alu_o, prev_alu);
        check({tag, ".err_stable"}, u_if.err_o, prev_err);
        u_if.a_i = 4'($urandom);
        u_if.b_i = 4'($urandom);
      end else begin
        check({tag, ".busy_done"}, u_if.alu_busy_o, 0);
        check({tag, ".alu"}, u_if.alu_o, exp_res);
        check({tag, ".err"}, u_if.err_o, exp_err);
      end
    end
    prev_alu = exp_res;
    prev_err = exp_err;
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, ".hold_busy"}, u_if.alu_busy_o, 0);
      check({tag, ".hold_alu"}, u_if.alu_o, prev_alu);
    end
    u_if.alu_op_i = 4'd0;
    step();
    check({tag, ".rearm_busy"}, u_if.alu_busy_o, 0);
    check({tag, ".rearm_alu"}, u_if.alu_o, prev_alu);
  endtask

  // Present a request that must be ignored in IDLE.
  task automatic run_ignored(input logic [3:0] op, input string tag);
    u_if.alu_op_i = op;
    u_if.a_i      = 4'($urandom);
    u_if.b_i      = 4'($urandom);
    #1;
    check({tag, ".busy"}, u_if.alu_busy_o, 0);
    step();
    check({tag, ".busy_next"}, u_if.alu_busy_o, 0);
    check({tag, ".alu"}, u_if.alu_o, prev_alu);
    check({tag, ".err"}, u_if.err_o, prev_err);
    u_if.alu_op_i = 4'd0;
    step();
  endtask

  initial begin
    logic [3:0] op;
    int         sel;
    n_checks = 0;
    n_pass   = 0;
    prev_alu = 8'h00;
    prev_err = 1'b0;
    rst           = 1'b0;
    u_if.alu_op_i = 4'b1000;
    u_if.a_i      = 4'd3;
    u_if.b_i      = 4'd4;

    // Reset with a request pending: busy must stay low.
    step();
    check("rst.busy", u_if.alu_busy_o, 0);
    step();
    check("rst.alu", u_if.alu_o, 8'h00);
    check("rst.err", u_if.err_o, 0);
    check("rst.busy2", u_if.alu_busy_o, 0);
    u_if.alu_op_i = 4'd0;
    rst = 1'b1;
    step();

    // Directed cases.
    run_op(4'd9,  4'd7, 4'b1000, 3,  "add");
    run_op(4'd2,  4'd5, 4'b0100, 10, "sub");
    run_op(4'd15, 4'd15, 4'b0010, 2, "mul");
    run_op(4'd13, 4'd4, 4'b0001, 1,  "div");
    run_op(4'd13, 4'd0, 4'b0001, 1,  "div0");
    run_op(4'd0,  4'd0, 4'b1000, 0,  "add0");
    run_op(4'd0,  4'd15, 4'b0100, 0, "submin");
    run_ignored(4'b0011, "illegal");
    run_ignored(4'b0000, "none");

    // Reset in the middle of a multiply.
    u_if.a_i      = 4'd7;
    u_if.b_i      = 4'd9;
    u_if.alu_op_i = 4'b0010;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rstmul.busy_in_rst", u_if.alu_busy_o, 0);
    step();
    rst = 1'b1;
    u_if.alu_op_i = 4'b0011;
    #1;
    check("rstmul.busy", u_if.alu_busy_o, 0);
    check("rstmul.alu", u_if.alu_o, 8'h00);
    check("rstmul.err", u_if.err_o, 0);
    prev_alu = 8'h00;
    prev_err = 1'b0;
    step();
    check("rstmul.noidle_start", u_if.alu_busy_o, 0);
    check("rstmul.alu_after", u_if.alu_o, 8'h00);
    u_if.alu_op_i = 4'd0;
    step();
    run_op(4'd1, 4'd1, 4'b1000, 0, "postrst");

    // Randomized mix of legal, illegal and empty requests.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 5));
      if (sel < 4) begin
        op = 4'b1000 >> sel;
        run_op(4'($urandom), 4'($urandom), op, int'($urandom_range(0, 4)), "rnd");
      end else if (sel == 4) begin
        do op = 4'($urandom); while ((op & (op - 4'd1)) == 4'd0);
        run_ignored(op, "rnd_illegal");
      end else begin
        run_ignored(4'd0, "rnd_none");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mini_alu.md
MINI_ALU -- requirements
Module: mini_alu

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous, active-low reset; sampled on posedge clk, rst==0 resets.
REQ-003 SHALL have port: alu_op_i  input  4  one-hot op request: 1000 add, 0100 sub, 0010 mul, 0001 div, 0000 none.
REQ-004 SHALL have port: a_i  input  4  operand A, unsigned, from sw[7:4].
REQ-005 SHALL have port: b_i  input  4  operand B, unsigned, from sw[3:0].
REQ-006 SHALL have port: alu_busy_o  output  1  high while an operation is accepted or in progress.
REQ-007 SHALL have port: alu_o  output  8  registered result of the last completed operation.
REQ-008 SHALL have port: err_o  output  1  registered error flag of the last completed operation.
REQ-009 SHALL have no parameters; operand width fixed at 4, result width fixed at 8.

Function
REQ-010 SHALL implement states IDLE, ADDSUB, MUL, DIV, DONE.
REQ-011 SHALL, in IDLE with alu_op_i exactly one-hot, latch a_i, b_i and op on that edge and move to ADDSUB (add/sub), MUL or DIV.
REQ-012 SHALL ignore alu_op_i in IDLE when 0000 or not one-hot (stay IDLE, busy low, alu_o/err_o unchanged).
REQ-013 SHALL drive alu_busy_o combinationally high in IDLE when alu_op_i is one-hot, and high in ADDSUB, MUL, DIV; low in DONE and otherwise in IDLE.
REQ-014 SHALL spend 1 cycle in ADDSUB, then go to DONE (acceptance cycle N, ADDSUB N+1, DONE N+2).
REQ-015 SHALL compute add as zero-extended A+B (0..30); sub as A-B sign-extended to 8-bit two's complement (e.g. 2-5 = 8'hFD).
REQ-016 SHALL compute mul by shift-and-add over exactly 4 cycles in MUL (N+1..N+4), DONE at N+5; alu_o = A*B (0..225).
REQ-017 SHALL compute div by restoring division over exactly 4 cycles in DIV, DONE at N+5; alu_o[7:4] = quotient, alu_o[3:0] = remainder.
REQ-018 SHALL, for div with latched B==0, skip iteration: go to DONE next cycle (N+2), alu_o = 8'hFF, err_o = 1.
REQ-019 SHALL update alu_o and err_o only on the edge entering DONE; err_o = 0 for every non-error completion.
REQ-020 SHALL hold alu_o stable while busy is high (intermediate values kept in internal registers).
REQ-021 SHALL ignore a_i, b_i, alu_op_i changes while in ADDSUB, MUL, DIV.
REQ-022 SHALL stay in DONE while alu_op_i != 0000 and return to IDLE on the edge where alu_op_i == 0000 (re-arm; a held request never restarts).
REQ-023 SHALL never start a new operation directly from DONE.

Reset
REQ-024 SHALL on rst==0 at posedge clk enter IDLE, clear alu_o to 8'h00, err_o to 0, all internal registers to 0.
REQ-025 SHALL abort any in-progress operation on reset without updating alu_o/err_o with partial results.
REQ-026 SHALL drive alu_busy_o low during reset cycles irrespective of alu_op_i.

Configuration
REQ-027 SHALL, with macro MINI_ALU_DIV_EN defined, implement DIV per REQ-017/018.
REQ-028 SHALL, without MINI_ALU_DIV_EN, omit DIV state and divider logic; op 0001 accepted, completes in DONE at N+2 with alu_o = 8'h00, err_o = 1.

Verification
REQ-029 SHALL test add: A=9, B=7, op 1000 held -> busy high N..N+1, low N+2, alu_o = 8'h10, err_o = 0.
REQ-030 SHALL test sub: A=2, B=5, op 0100 -> alu_o = 8'hFD at N+2; op held 10 more cycles -> no restart, busy stays low.
REQ-031 SHALL test mul: A=15, B=15, op 0010 -> busy high N..N+4, alu_o = 8'hE1 at N+5, alu_o unchanged N..N+4.
REQ-032 SHALL test div: A=13, B=4 -> alu_o = 8'h31 at N+5; then B=0 -> alu_o = 8'hFF, err_o = 1 at N+2 (without MINI_ALU_DIV_EN: 8'h00, err_o = 1).
REQ-033 SHALL test reset mid-mul: rst=0 at N+2 -> next edge IDLE, busy low, alu_o = 8'h00; illegal op 0011 afterwards -> no start.
